// File: rtl/riscv_pkg.sv
// Shared RV32 front-end types: the 32-bit word type, the NOP encoding,
// the fetch FSM state encoding and a word-alignment helper.
package riscv_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic word_t align_word(input word_t addr);
    return addr & ~word_t'(32'h3);
  endfunction

endpackage

// File: rtl/if_output_buffer.sv
// Decode-facing output register plus a one-entry hold buffer that parks a
// word accepted from memory while decode is stalled.
module if_output_buffer
  import riscv_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  bubble,
  input  logic  store,
  input  logic  hold_release,
  input  logic  flush,
  input  word_t in_instr,
  input  word_t in_pc,
  output word_t instruction,
  output word_t pc_out,
  output logic  instr_valid
);

  word_t instr_q, instr_d;
  word_t pc_q, pc_d;
  logic  valid_q, valid_d;
  word_t buf_instr_q, buf_instr_d;
  word_t buf_pc_q, buf_pc_d;
  logic  buf_valid_q, buf_valid_d;

  always_comb begin
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    if (flush) begin
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end else begin
      if (load) begin
        instr_d = in_instr;
        pc_d    = in_pc;
        valid_d = 1'b1;
      end else if (hold_release) begin
        instr_d     = buf_instr_q;
        pc_d        = buf_pc_q;
        valid_d     = buf_valid_q;
        buf_valid_d = 1'b0;
      end else if (bubble) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      if (store) begin
        buf_instr_d = in_instr;
        buf_pc_d    = in_pc;
        buf_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q     <= NOP_INSTR;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Parked word and PC are qualified by buf_valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    buf_instr_q <= buf_instr_d;
    buf_pc_q    <= buf_pc_d;
  end

  assign instruction = instr_q;
  assign pc_out      = pc_q;
  assign instr_valid = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32 instruction fetch: PC, fetch FSM (FETCH/HOLD/DRAIN) and redirect handling.
// Define IF_FETCH_STATS_EN to add fetch_count / bubble_count statistics outputs.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter word_t RESET_PC  = 32'h0000_0000,
  parameter word_t NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busy,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4,
  output logic        instr_valid
`ifdef IF_FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        target_q, target_d;
  word_t        redirect_pc;
  logic         accept;
  logic         out_load, out_bubble, buf_store, buf_release, out_flush;

  assign imem_read    = !reset && (state_q != HOLD);
  assign imem_address = pc_q;
  assign accept       = imem_read && !imem_busy;
  assign redirect_pc  = align_word(redirect_target);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    out_load    = 1'b0;
    out_bubble  = 1'b0;
    buf_store   = 1'b0;
    buf_release = 1'b0;
    out_flush   = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          out_flush = 1'b1;
          if (imem_busy) begin
            target_d = redirect_pc;
            state_d  = DRAIN;
          end else begin
            pc_d = redirect_pc;
          end
        end else if (accept) begin
          pc_d = pc_q + 32'd4;
          if (stall) begin
            buf_store = 1'b1;
            state_d   = HOLD;
          end else begin
            out_load = 1'b1;
          end
        end else if (!stall) begin
          out_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          out_flush = 1'b1;
          pc_d      = redirect_pc;
          state_d   = FETCH;
        end else if (!stall) begin
          buf_release = 1'b1;
          state_d     = FETCH;
        end
      end
      DRAIN: begin
        // The in-flight access must finish at its original address; its data is dropped.
        out_flush = redirect;
        if (!imem_busy) begin
          pc_d    = redirect ? redirect_pc : target_q;
          state_d = FETCH;
        end else if (redirect) begin
          target_d = redirect_pc;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    target_q <= target_d;
  end

  if_output_buffer #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) u_out_buf (
    .clk         (clk),
    .reset       (reset),
    .load        (out_load),
    .bubble      (out_bubble),
    .store       (buf_store),
    .hold_release(buf_release),
    .flush       (out_flush),
    .in_instr    (imem_readdata),
    .in_pc       (pc_q),
    .instruction (instruction),
    .pc_out      (pc_out),
    .instr_valid (instr_valid)
  );

  assign pc_plus_4 = pc_out + 32'd4;

`ifdef IF_FETCH_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    fetch_count_d  = fetch_count_q + {31'd0, (out_load | buf_release)};
    bubble_count_d = bubble_count_q + {31'd0, !instr_valid};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q  <= 32'd0;
      bubble_count_q <= 32'd0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then randomized
// stall/busy/redirect/reset traffic against a rule-level reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_busy;
  logic [31:0] redirect_target, imem_readdata;
  logic        imem_read, instr_valid;
  logic [31:0] imem_address, instruction, pc_out, pc_plus_4;
`ifdef IF_FETCH_STATS_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_readdata  (imem_readdata),
    .imem_busy      (imem_busy),
    .instruction    (instruction),
    .pc_out         (pc_out),
    .pc_plus_4      (pc_plus_4),
    .instr_valid    (instr_valid)
`ifdef IF_FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Odd multiplier makes every address map to a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  // Reference model: architectural PC, a queue for the parked word, a drain flag.
  logic [31:0] m_pc, m_target, m_instr, m_pcout;
  logic        m_valid, m_draining;
  logic [31:0] m_hold_i[$];
  logic [31:0] m_hold_p[$];
  logic [31:0] m_fc, m_bc;
  logic        last_read;
  logic [31:0] last_addr;

  task automatic cycle(input logic r, input logic st, input logic rd,
                       input logic [31:0] tgt, input logic bz);
    logic        m_read, acc;
    logic [31:0] t;
    reset = r; stall = st; redirect = rd; redirect_target = tgt; imem_busy = bz;
    imem_readdata = bz ? 32'hBAD0_BAD0 : mem_word(imem_address);
    #1;
    m_read = !r && (m_hold_i.size() == 0);
    check("imem_read", {31'd0, imem_read}, {31'd0, m_read});
    if (m_read) check("imem_address", imem_address, m_pc);
    last_read = imem_read;
    last_addr = imem_address;

    acc = m_read && !bz;
    t   = tgt & ~32'h3;
    if (r) begin
      m_pc = RST_PC; m_draining = 1'b0; m_hold_i.delete(); m_hold_p.delete();
      m_instr = NOP; m_pcout = RST_PC; m_valid = 1'b0; m_fc = 0; m_bc = 0;
    end else begin
      if (!m_valid) m_bc++;
      if (rd) begin
        m_instr = NOP; m_valid = 1'b0; m_hold_i.delete(); m_hold_p.delete();
        if (m_read && bz) begin m_draining = 1'b1; m_target = t; end
        else begin m_pc = t; m_draining = 1'b0; end
      end else if (m_draining) begin
        if (!bz) begin m_pc = m_target; m_draining = 1'b0; end
      end else if (m_hold_i.size() != 0) begin
        if (!st) begin
          m_instr = m_hold_i.pop_front(); m_pcout = m_hold_p.pop_front();
          m_valid = 1'b1; m_fc++;
        end
      end else if (acc) begin
        if (st) begin m_hold_i.push_back(mem_word(m_pc)); m_hold_p.push_back(m_pc); end
        else begin m_instr = mem_word(m_pc); m_pcout = m_pc; m_valid = 1'b1; m_fc++; end
        m_pc = m_pc + 32'd4;
      end else if (!st) begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    check("instruction", instruction, m_instr);
    if (m_valid) begin
      check("pc_out", pc_out, m_pcout);
      check("pc_plus_4", pc_plus_4, m_pcout + 32'd4);
    end
`ifdef IF_FETCH_STATS_EN
    check("fetch_count", fetch_count, m_fc);
    check("bubble_count", bubble_count, m_bc);
`endif
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
    imem_busy = 1'b0; imem_readdata = '0;

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_instruction", instruction, NOP);
    check("rst_pc_out", pc_out, RST_PC);
    check("rst_pc_plus_4", pc_plus_4, RST_PC + 32'd4);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);

    // Zero-wait start, then two wait states at 0x104.
    cycle(0, 0, 0, 0, 0);
    check("first_addr", last_addr, 32'h100);
    check("first_valid", {31'd0, instr_valid}, 32'd1);
    check("first_pc_out", pc_out, 32'h100);
    cycle(0, 0, 0, 0, 1);
    check("busy_addr1", last_addr, 32'h104);
    check("busy_bubble1", {31'd0, instr_valid}, 32'd0);
    cycle(0, 0, 0, 0, 1);
    check("busy_addr2", last_addr, 32'h104);
    check("busy_bubble2", {31'd0, instr_valid}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("busy_addr3", last_addr, 32'h104);
    check("busy_word", instruction, mem_word(32'h104));

    // Stall for three cycles starting with the 0x108 accept.
    cycle(0, 1, 0, 0, 0);
    check("stall_accept_addr", last_addr, 32'h108);
    check("stall_frozen1", pc_out, 32'h104);
    cycle(0, 1, 0, 0, 0);
    check("hold_read1", {31'd0, last_read}, 32'd0);
    check("stall_frozen2", pc_out, 32'h104);
    cycle(0, 1, 0, 0, 0);
    check("stall_frozen3", instruction, mem_word(32'h104));
    cycle(0, 0, 0, 0, 0);
    check("hold_read2", {31'd0, last_read}, 32'd0);
    check("release_pc", pc_out, 32'h108);
    check("release_word", instruction, mem_word(32'h108));
    cycle(0, 0, 0, 0, 0);
    check("resume_addr", last_addr, 32'h10C);
    check("resume_pc", pc_out, 32'h10C);

    // Redirect with stall and accept in the same cycle.
    cycle(0, 1, 1, 32'h203, 0);
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_nop", instruction, NOP);
    cycle(0, 0, 0, 0, 0);
    check("redir_addr", last_addr, 32'h200);
    check("redir_pc", pc_out, 32'h200);

    // Redirect while busy at 0x110 -> drain.
    cycle(0, 0, 1, 32'h110, 0);
    cycle(0, 0, 1, 32'h400, 1);
    check("drain_addr1", last_addr, 32'h110);
    cycle(0, 0, 0, 0, 1);
    check("drain_addr2", last_addr, 32'h110);
    cycle(0, 0, 0, 0, 0);
    check("drain_addr3", last_addr, 32'h110);
    check("drain_discard", {31'd0, instr_valid}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("drain_next_addr", last_addr, 32'h400);
    check("drain_target_pc", pc_out, 32'h400);

    // PC wrap at the top of the address space.
    cycle(0, 0, 1, 32'hFFFF_FFFF, 0);
    cycle(0, 0, 0, 0, 0);
    check("wrap_addr_top", last_addr, 32'hFFFF_FFFC);
    check("wrap_pc_plus_4", pc_plus_4, 32'h0);
    cycle(0, 0, 0, 0, 0);
    check("wrap_addr_zero", last_addr, 32'h0);

`ifdef IF_FETCH_STATS_EN
    cycle(1, 0, 0, 0, 0);
    check("stats_rst_fetch", fetch_count, 32'd0);
    check("stats_rst_bubble", bubble_count, 32'd0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0, 0);
    check("stats_fetch10", fetch_count, 32'd10);
    check("stats_bubble3", bubble_count, 32'd3);
`endif

    // Randomized traffic, including occasional mid-access resets.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) == 0, $urandom_range(99) < 30, $urandom_range(99) < 8,
            $urandom, $urandom_range(99) < 30);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
